// File: rtl/subr8s_pkg.sv
// Shared widths for the self-checking signed subtractor pipeline.
package subr8s_pkg;
  localparam int W        = 8;
  localparam int ERRCNT_W = 8;
  localparam int DIFF_W   = W + 1;
endpackage

// File: rtl/subr8s_pipe_chk_if.sv
// Operand and result handshakes of the checked subtractor pipeline.
interface subr8s_pipe_chk_if;
  import subr8s_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [W-1:0]      a;
  logic signed [W-1:0]      b;
  logic                     fault_inj;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DIFF_W-1:0] diff;
  logic                     chk_err;

  modport master (
    output in_valid, a, b, fault_inj, out_ready,
    input  in_ready, out_valid, diff, chk_err
  );

  modport slave (
    input  in_valid, a, b, fault_inj, out_ready,
    output in_ready, out_valid, diff, chk_err
  );
endinterface

// File: rtl/subr8s_core.sv
// Combinational ripple-carry adder with carry-in; the subtract and check paths
// each get their own instance so a carry-chain defect cannot hide itself.
module subr8s_core
  import subr8s_pkg::*;
#(
  parameter int DATA_W = DIFF_W
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              cin,
  output logic [DATA_W-1:0] sum
);
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < DATA_W; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
  end
endmodule

// File: rtl/subr8s_pipe_chk.sv
// Two-stage signed subtractor with re-add check, fault-inject hook and a
// saturating fault counter; valid/ready on both sides.
module subr8s_pipe_chk
  import subr8s_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  subr8s_pipe_chk_if.slave    bus,
  input  logic                err_clr,
  output logic [ERRCNT_W-1:0] err_cnt
);
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                     vld_p1, vld_p2;
  logic                     adv1, adv2, fire;
  logic signed [W-1:0]      a_p1, b_p1;
  logic                     inj_p1;
  logic signed [DIFF_W-1:0] a_sx, b_sx, d_raw, d_fix, chk_sum, d_p2;
  logic                     chk_n, chk_p2;

  assign adv2         = !vld_p2 || bus.out_ready;
  assign adv1         = !vld_p1 || adv2;
  assign bus.in_ready = adv1;
  assign fire         = vld_p2 && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= bus.in_valid;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: operand capture, subtract, fault inject, re-add check ----
  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      a_p1   <= bus.a;
      b_p1   <= bus.b;
      inj_p1 <= bus.fault_inj;
    end
  end

  assign a_sx = {a_p1[W-1], a_p1};
  assign b_sx = {b_p1[W-1], b_p1};

  subr8s_core #(.DATA_W(DIFF_W)) u_sub (
    .x   (a_sx),
    .y   (~b_sx),
    .cin (1'b1),
    .sum (d_raw)
  );

  assign d_fix = {d_raw[DIFF_W-1:1], d_raw[0] ^ inj_p1};

  subr8s_core #(.DATA_W(DIFF_W)) u_chk (
    .x   (d_fix),
    .y   (b_sx),
    .cin (1'b0),
    .sum (chk_sum)
  );

  assign chk_n = (chk_sum != a_sx);

  // ---- stage 2: result register, held while downstream stalls ----
  always_ff @(posedge clk) begin
    if (adv2 && vld_p1) begin
      d_p2   <= d_fix;
      chk_p2 <= chk_n;
    end
  end

  // Data registers carry no reset; gating by valid keeps outputs at zero out of reset.
  assign bus.out_valid = vld_p2;
  assign bus.diff      = vld_p2 ? d_p2 : '0;
  assign bus.chk_err   = vld_p2 && chk_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (fire && chk_p2) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
endmodule
